datapath_pipe: RTL and testbench
================================

# datapath_pipe

Parametrised two-stage register-file datapath, the next generation of the fixed 8×16-bit control-word datapath. Each accepted control word reads two registers or a constant, runs the function unit, and writes back the result and V/C/N/Z flags. Control words arrive through a valid/ready handshake, and read-after-write hazards are resolved in hardware. The block sits between the control-word sequencer and the memory/IO side; all registers are exported for bench dumps.

## Interface
- WIDTH, 16: data width, 4 or more.
- NREGS, 8: register count, a power of two, 2 or more; AW = log2(NREGS).
- CW_W, derived: control word width, 3·AW+WIDTH+7.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- cw  in  CW_W  control word, MSB→LSB: RW, DA[AW], AA[AW], BA[AW], MB, FS[4], MD, CONST[WIDTH].
- cw_valid  in  1  cw is valid this cycle.
- cw_ready  out  1  block accepts cw this cycle.
- data_in  in  WIDTH  external data, written back when MD=1.
- addr_out  out  WIDTH  registered A operand of the EX stage.
- data_out  out  WIDTH  registered B operand (after the MB mux) of the EX stage.
- v, c, n, z  out  1 each  status flags.
- regs_flat  out  NREGS·WIDTH  register file; R0 is the LSBs.
- busy  out  1  EX stage holds a valid op.

## Operation
- Accept when cw_valid && cw_ready. Decode/read stage: latch A=R[AA], B = MB ? CONST : R[BA], plus RW, DA, FS, MD into EX registers, and set ex_valid.
- EX stage: function unit F = f(A,B,FS). At the next edge, if RW, R[DA] ← MD ? data_in : F.
- Flags update on every executed op, whether RW is 0 or 1.
- FS encoding (arithmetic is WIDTH-bit, carry-out into c):
  - 0: A
  - 1: A+1
  - 2: A+B
  - 3: A+B+1
  - 4: A+~B
  - 5: A+~B+1
  - 6: A−1
  - 7: A (alias)
  - 8: A&B
  - 9: A|B
  - 10: A^B
  - 11: ~A
  - 12: B
  - 13: B>>1 (logical)
  - 14: B<<1
  - 15: B rotate-left 1
- v and c update only for FS 0–7; they hold for FS 8–15. v is two's-complement overflow of the add. n=F[WIDTH-1] and z=(F==0) update on every op; when MD=1 they reflect F, not data_in.
- Hazard: the incoming AA, or BA with MB=0, equals the EX DA while EX has RW=1 and ex_valid.
- Without forwarding, cw_ready=0 for one cycle (one bubble).
- Idle cycles (no accept) clear ex_valid. Registers and flags hold.

## Timing
- Latency: cw accepted at edge k → register and flags visible after edge k+1.
- Throughput: 1 op/cycle with no hazard.
- Reset, asynchronous and immediate:
  - all registers, v/c/n/z, addr_out, data_out = 0
  - ex_valid=0, busy=0
  - cw_ready=0 while rst=1, and 1 from the first cycle after release
- Reset mid-operation discards the in-flight op with no writeback.
- cw_ready is combinational from the hazard check only and never depends on cw_valid.
- Simultaneous writeback and read of the same register in the same cycle: the read returns the new value via forwarding or a stall. A stale value is never returned.
- DA=AA=BA on the same op reads the old value and writes the new one.

## Configuration
- DATAPATH_FORWARD_EN defined: EX result (data_in when MD=1) is muxed into the decode operands on a hazard. cw_ready depends only on rst, so back-to-back dependent ops run with no bubble.
- Undefined: no bypass. A hazard drops cw_ready for exactly one cycle; the op is accepted on the following cycle and reads the written-back value.

## Structure
- datapath_pkg holds:
  - FS localparams (FS_A … FS_ROL)
  - functions returning cw field offsets for given WIDTH and AW
  - a helper for the flag struct {v,c,n,z}
- Sub-module datapath_fu: combinational function unit, parametrised by WIDTH. Outputs F, cout, ovf.
- datapath_pipe contains the register file, the EX pipeline registers, the hazard/forward logic and the flags.

## Test plan
- Reset: assert rst mid-stream → regs_flat=0, flags 0000, busy=0; cw_ready=1 one cycle after release.
- Constant load: R1←0x7FFF, R2←0x0001 (FS=12, MB=1), then R3←R1+R2 → R3=0x8000, v=1, c=0, n=1, z=0.
- Subtract: R4←R2−R2 (FS=5) → 0x0000, z=1, c=1, v=0.
- Dependency: R1←0x0005, then R5←R1+1 on the next cycle with cw_valid held → R5=0x0006. With DATAPATH_FORWARD_EN: no cw_ready drop. Without: exactly one cycle with cw_ready=0.
- Shifts and logic, with R1 still 0x7FFF from the constant-load scenario:
  - R6←B<<1 of 0x8001 → 0x0002, v/c unchanged
  - R7←R1 ^ 0xFFFF → 0x8000, n=1
- MD path: data_in=0xA5A5, MD=1, RW=1, DA=0 → R0=0xA5A5 one edge after accept. Flags reflect F, not data_in.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg: shared definitions for the register-file datapath.
//   - FS_* function-select codes for the function unit
//   - flags_t status-flag struct {v, c, n, z} and its update helper
//   - control-word field offsets as functions of WIDTH and AW
// Control word layout, MSB->LSB: RW, DA[AW], AA[AW], BA[AW], MB, FS[4], MD, CONST[WIDTH].
package datapath_pkg;

    localparam logic [3:0] FS_A    = 4'd0;
    localparam logic [3:0] FS_INC  = 4'd1;
    localparam logic [3:0] FS_ADD  = 4'd2;
    localparam logic [3:0] FS_ADDC = 4'd3;
    localparam logic [3:0] FS_SUBB = 4'd4;
    localparam logic [3:0] FS_SUB  = 4'd5;
    localparam logic [3:0] FS_DEC  = 4'd6;
    localparam logic [3:0] FS_A2   = 4'd7;
    localparam logic [3:0] FS_AND  = 4'd8;
    localparam logic [3:0] FS_OR   = 4'd9;
    localparam logic [3:0] FS_XOR  = 4'd10;
    localparam logic [3:0] FS_NOT  = 4'd11;
    localparam logic [3:0] FS_B    = 4'd12;
    localparam logic [3:0] FS_SHR  = 4'd13;
    localparam logic [3:0] FS_SHL  = 4'd14;
    localparam logic [3:0] FS_ROL  = 4'd15;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

    function automatic int unsigned cw_const_lsb(int unsigned width);
        return 0 + (width - width);
    endfunction

    function automatic int unsigned cw_md_pos(int unsigned width);
        return width;
    endfunction

    function automatic int unsigned cw_fs_lsb(int unsigned width);
        return width + 1;
    endfunction

    function automatic int unsigned cw_mb_pos(int unsigned width);
        return width + 5;
    endfunction

    function automatic int unsigned cw_ba_lsb(int unsigned width);
        return width + 6;
    endfunction

    function automatic int unsigned cw_aa_lsb(int unsigned width, int unsigned aw);
        return width + 6 + aw;
    endfunction

    function automatic int unsigned cw_da_lsb(int unsigned width, int unsigned aw);
        return width + 6 + 2 * aw;
    endfunction

    function automatic int unsigned cw_rw_pos(int unsigned width, int unsigned aw);
        return width + 6 + 3 * aw;
    endfunction

    // v/c only follow the arithmetic codes (FS[3]=0); n/z always follow F.
    function automatic flags_t next_flags(flags_t cur, logic [3:0] fs, logic ovf, logic cout,
                                          logic msb, logic zero);
        flags_t nxt;
        nxt = cur;
        if (!fs[3]) begin
            nxt.v = ovf;
            nxt.c = cout;
        end
        nxt.n = msb;
        nxt.z = zero;
        return nxt;
    endfunction

endpackage

// File: rtl/datapath_fu.sv
// datapath_fu: combinational function unit.
//   i_a, i_b : operands (WIDTH)
//   i_fs     : function select (FS_* codes)
//   o_f      : result
//   o_cout   : carry out of the WIDTH-bit add (meaningful for FS 0-7)
//   o_ovf    : two's-complement overflow of the add (meaningful for FS 0-7)
module datapath_fu
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_fs,
    output logic [WIDTH-1:0] o_f,
    output logic             o_cout,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;

    // All arithmetic codes are A + Y + cin; A-1 is A plus all-ones.
    always_comb begin
        w_y   = '0;
        w_cin = 1'b0;
        case (i_fs)
            FS_INC:  w_cin = 1'b1;
            FS_ADD:  w_y = i_b;
            FS_ADDC: begin
                w_y   = i_b;
                w_cin = 1'b1;
            end
            FS_SUBB: w_y = ~i_b;
            FS_SUB:  begin
                w_y   = ~i_b;
                w_cin = 1'b1;
            end
            FS_DEC:  w_y = '1;
            default: ;
        endcase
    end

    assign w_sum  = {1'b0, i_a} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
    assign o_cout = w_sum[WIDTH];
    assign o_ovf  = (i_a[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

    always_comb begin
        o_f = '0;
        unique case (i_fs)
            FS_A, FS_INC, FS_ADD, FS_ADDC,
            FS_SUBB, FS_SUB, FS_DEC, FS_A2: o_f = w_sum[WIDTH-1:0];
            FS_AND: o_f = i_a & i_b;
            FS_OR:  o_f = i_a | i_b;
            FS_XOR: o_f = i_a ^ i_b;
            FS_NOT: o_f = ~i_a;
            FS_B:   o_f = i_b;
            FS_SHR: o_f = {1'b0, i_b[WIDTH-1:1]};
            FS_SHL: o_f = {i_b[WIDTH-2:0], 1'b0};
            FS_ROL: o_f = {i_b[WIDTH-2:0], i_b[WIDTH-1]};
        endcase
    end

endmodule

// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage register-file datapath (decode/read -> execute/writeback).
//   clk, rst           : clock, asynchronous active-high reset
//   cw, cw_valid       : control word {RW, DA, AA, BA, MB, FS, MD, CONST} and its valid
//   cw_ready           : control word accepted this cycle when cw_valid is also high
//   data_in            : external data written back when MD=1
//   addr_out, data_out : registered A and B operands of the EX stage
//   v, c, n, z         : status flags
//   regs_flat          : register file, R0 in the LSBs
//   busy               : EX stage holds a valid op
// Build option DATAPATH_FORWARD_EN: bypass the EX writeback value into the decode operands
// instead of stalling one cycle on a read-after-write hazard.
module datapath_pipe
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 8,
    localparam int unsigned AW   = $clog2(NREGS),
    localparam int unsigned CW_W = 3 * AW + WIDTH + 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CW_W-1:0]        cw,
    input  logic                   cw_valid,
    output logic                   cw_ready,
    input  logic [WIDTH-1:0]       data_in,
    output logic [WIDTH-1:0]       addr_out,
    output logic [WIDTH-1:0]       data_out,
    output logic                   v,
    output logic                   c,
    output logic                   n,
    output logic                   z,
    output logic [NREGS*WIDTH-1:0] regs_flat,
    output logic                   busy
);

    localparam int unsigned CONST_LSB = cw_const_lsb(WIDTH);
    localparam int unsigned MD_POS    = cw_md_pos(WIDTH);
    localparam int unsigned FS_LSB    = cw_fs_lsb(WIDTH);
    localparam int unsigned MB_POS    = cw_mb_pos(WIDTH);
    localparam int unsigned BA_LSB    = cw_ba_lsb(WIDTH);
    localparam int unsigned AA_LSB    = cw_aa_lsb(WIDTH, AW);
    localparam int unsigned DA_LSB    = cw_da_lsb(WIDTH, AW);
    localparam int unsigned RW_POS    = cw_rw_pos(WIDTH, AW);

    // Control word fields
    logic             w_rw;
    logic [AW-1:0]    w_da;
    logic [AW-1:0]    w_aa;
    logic [AW-1:0]    w_ba;
    logic             w_mb;
    logic [3:0]       w_fs;
    logic             w_md;
    logic [WIDTH-1:0] w_const;

    assign w_rw    = cw[RW_POS];
    assign w_da    = cw[DA_LSB +: AW];
    assign w_aa    = cw[AA_LSB +: AW];
    assign w_ba    = cw[BA_LSB +: AW];
    assign w_mb    = cw[MB_POS];
    assign w_fs    = cw[FS_LSB +: 4];
    assign w_md    = cw[MD_POS];
    assign w_const = cw[CONST_LSB +: WIDTH];

    // Register file and EX pipeline state
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_rw;
    logic [AW-1:0]    r_da;
    logic [3:0]       r_fs;
    logic             r_md;
    logic             r_ex_valid;
    flags_t           r_flags;

    logic [WIDTH-1:0] w_f;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_wb_data;
    logic             w_hit_a;
    logic             w_hit_b;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b_reg;
    logic             w_accept;

    datapath_fu #(
        .WIDTH(WIDTH)
    ) u_fu (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_fs  (r_fs),
        .o_f   (w_f),
        .o_cout(w_cout),
        .o_ovf (w_ovf)
    );

    assign w_wb_data = r_md ? data_in : w_f;

    // The EX op writes back on the same edge this decode reads, so a match means the
    // register file still holds the stale value.
    assign w_hit_a = r_ex_valid && r_rw && (w_aa == r_da);
    assign w_hit_b = r_ex_valid && r_rw && !w_mb && (w_ba == r_da);

`ifdef DATAPATH_FORWARD_EN
    assign w_op_a     = w_hit_a ? w_wb_data : r_regs[w_aa];
    assign w_op_b_reg = w_hit_b ? w_wb_data : r_regs[w_ba];
    assign cw_ready   = !rst;
`else
    assign w_op_a     = r_regs[w_aa];
    assign w_op_b_reg = r_regs[w_ba];
    // One bubble lets the writeback land before the dependent read.
    assign cw_ready   = !rst && !(w_hit_a || w_hit_b);
`endif

    assign w_accept = cw_valid && cw_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_rw       <= 1'b0;
            r_da       <= '0;
            r_fs       <= FS_A;
            r_md       <= 1'b0;
            r_ex_valid <= 1'b0;
        end else begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_a  <= w_op_a;
                r_b  <= w_mb ? w_const : w_op_b_reg;
                r_rw <= w_rw;
                r_da <= w_da;
                r_fs <= w_fs;
                r_md <= w_md;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_ex_valid && r_rw) begin
            r_regs[r_da] <= w_wb_data;
        end
    end

    // n/z follow F even when MD selects data_in for writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
        end else if (r_ex_valid) begin
            r_flags <= next_flags(r_flags, r_fs, w_ovf, w_cout, w_f[WIDTH-1], (w_f == '0));
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
    end

    assign addr_out = r_a;
    assign data_out = r_b;
    assign v        = r_flags.v;
    assign c        = r_flags.c;
    assign n        = r_flags.n;
    assign z        = r_flags.z;
    assign busy     = r_ex_valid;

endmodule

// File: tb/tb_datapath_pipe.sv
// tb_datapath_pipe: directed bench for datapath_pipe (WIDTH=16, NREGS=8, 32-bit cw).
// Expected register values and flags are pushed to a scoreboard when each control word is
// driven and compared two falling edges after the handshake, i.e. after the writeback edge.
module tb_datapath_pipe;

    typedef struct {
        logic        rw;
        int unsigned rd;
        logic [15:0] val;
        logic [3:0]  vcnz;
    } exp_t;

`ifdef DATAPATH_FORWARD_EN
    localparam int EXP_DEP_STALL = 0;
`else
    localparam int EXP_DEP_STALL = 1;
`endif

    logic         clk;
    logic         rst;
    logic [31:0]  cw;
    logic         cw_valid;
    logic         cw_ready;
    logic [15:0]  data_in;
    logic [15:0]  addr_out;
    logic [15:0]  data_out;
    logic         v, c, n, z;
    logic [127:0] regs_flat;
    logic         busy;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    logic due1    = 1'b0;
    logic due2    = 1'b0;

    datapath_pipe #(
        .WIDTH(16),
        .NREGS(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cw       (cw),
        .cw_valid (cw_valid),
        .cw_ready (cw_ready),
        .data_in  (data_in),
        .addr_out (addr_out),
        .data_out (data_out),
        .v        (v),
        .c        (c),
        .n        (n),
        .z        (z),
        .regs_flat(regs_flat),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk_cw(logic rw, logic [2:0] da, logic [2:0] aa,
                                          logic [2:0] ba, logic mb, logic [3:0] fs,
                                          logic md, logic [15:0] k);
        return {rw, da, aa, ba, mb, fs, md, k};
    endfunction

    function automatic exp_t mk_exp(logic rw, int unsigned rd, logic [15:0] val,
                                    logic [3:0] vcnz);
        exp_t e;
        e.rw   = rw;
        e.rd   = rd;
        e.val  = val;
        e.vcnz = vcnz;
        return e;
    endfunction

    // Entered and left at posedge+1; cw_valid stays high across back-to-back calls.
    task automatic send(input logic [31:0] w, input exp_t e, input bit push, output int stalls);
        if (push) sb.push_back(e);
        cw       = w;
        cw_valid = 1'b1;
        stalls   = 0;
        forever begin
            @(negedge clk);
            if (cw_ready) break;
            stalls++;
            if (stalls > 10) begin
                chk("accept_timeout", 128'(stalls), 128'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        cw_valid = 1'b0;
    endtask

    // Result monitor: handshake seen at a falling edge -> writeback visible two falling
    // edges later.
    always @(negedge clk) begin
        if (rst) begin
            due1 <= 1'b0;
            due2 <= 1'b0;
        end else begin
            if (due2) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_underflow", 128'(1), 128'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.rw) chk($sformatf("R%0d", e.rd), 128'(regs_flat[e.rd*16 +: 16]),
                                  128'(e.val));
                    chk($sformatf("vcnz_after_R%0d", e.rd), 128'({v, c, n, z}), 128'(e.vcnz));
                end
            end
            due2 <= due1;
            due1 <= cw_valid && cw_ready;
        end
    end

    initial begin
        int st;
        rst      = 1'b1;
        cw       = '0;
        cw_valid = 1'b0;
        data_in  = 16'h0000;
        #3;
        chk("rst_regs", regs_flat, 128'(0));
        chk("rst_flags", 128'({v, c, n, z}), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ready", 128'(cw_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_release", 128'(cw_ready), 128'(1));

        // Constant loads and add with signed overflow
        send(mk_cw(1, 1, 0, 0, 1, 4'd12, 0, 16'h7FFF), mk_exp(1, 1, 16'h7FFF, 4'b0000), 1, st);
        send(mk_cw(1, 2, 0, 0, 1, 4'd12, 0, 16'h0001), mk_exp(1, 2, 16'h0001, 4'b0000), 1, st);
        send(mk_cw(1, 3, 1, 2, 0, 4'd2, 0, 16'h0000), mk_exp(1, 3, 16'h8000, 4'b1010), 1, st);
        chk("addr_out_add", 128'(addr_out), 128'(16'h7FFF));
        chk("data_out_add", 128'(data_out), 128'(16'h0001));
        // Subtract to zero: independent of the previous op, so no bubble
        send(mk_cw(1, 4, 2, 2, 0, 4'd5, 0, 16'h0000), mk_exp(1, 4, 16'h0000, 4'b0101), 1, st);
        chk("sub_no_stall", 128'(st), 128'(0));
        // Shift / xor: v and c hold
        send(mk_cw(1, 6, 0, 0, 1, 4'd14, 0, 16'h8001), mk_exp(1, 6, 16'h0002, 4'b0100), 1, st);
        chk("shl_no_stall", 128'(st), 128'(0));
        send(mk_cw(1, 7, 1, 0, 1, 4'd10, 0, 16'hFFFF), mk_exp(1, 7, 16'h8000, 4'b0110), 1, st);
        // MD writeback: R0 gets data_in, flags follow F = R4 = 0
        data_in = 16'hA5A5;
        send(mk_cw(1, 0, 4, 0, 0, 4'd0, 1, 16'h0000), mk_exp(1, 0, 16'hA5A5, 4'b0001), 1, st);
        // Dependent pair with valid held
        send(mk_cw(1, 1, 0, 0, 1, 4'd12, 0, 16'h0005), mk_exp(1, 1, 16'h0005, 4'b0000), 1, st);
        send(mk_cw(1, 5, 1, 0, 0, 4'd1, 0, 16'h0000), mk_exp(1, 5, 16'h0006, 4'b0000), 1, st);
        chk("dep_stall_cycles", 128'(st), 128'(EXP_DEP_STALL));
        // Rotate, decrement of zero
        send(mk_cw(1, 6, 0, 0, 1, 4'd15, 0, 16'h8001), mk_exp(1, 6, 16'h0003, 4'b0000), 1, st);
        send(mk_cw(1, 7, 4, 0, 0, 4'd6, 0, 16'h0000), mk_exp(1, 7, 16'hFFFF, 4'b0010), 1, st);
        // DA=AA=BA reads old value; the next op depends on it through A
        send(mk_cw(1, 2, 2, 2, 0, 4'd2, 0, 16'h0000), mk_exp(1, 2, 16'h0002, 4'b0000), 1, st);
        send(mk_cw(1, 3, 2, 0, 1, 4'd0, 0, 16'h0000), mk_exp(1, 3, 16'h0002, 4'b0000), 1, st);
        chk("dep_stall_cycles_2", 128'(st), 128'(EXP_DEP_STALL));
        // RW=0 still updates flags: 6 + 0xFFFA carries out to zero
        send(mk_cw(0, 0, 5, 0, 1, 4'd2, 0, 16'hFFFA), mk_exp(0, 0, 16'h0000, 4'b0101), 1, st);
        send(mk_cw(1, 4, 0, 0, 1, 4'd13, 0, 16'h8001), mk_exp(1, 4, 16'h4000, 4'b0100), 1, st);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        chk("final_regs", regs_flat,
            {16'hFFFF, 16'h0003, 16'h0006, 16'h4000, 16'h0002, 16'h0002, 16'h0005, 16'hA5A5});
        chk("idle_busy", 128'(busy), 128'(0));

        // Reset with an op in EX: it must be discarded
        @(posedge clk);
        #1;
        send(mk_cw(1, 7, 0, 0, 1, 4'd12, 0, 16'h1234), mk_exp(1, 7, 16'h1234, 4'b0000), 0, st);
        chk("inflight_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        chk("midrst_regs", regs_flat, 128'(0));
        chk("midrst_flags", 128'({v, c, n, z}), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_ready", 128'(cw_ready), 128'(0));
        chk("midrst_operands", 128'({addr_out, data_out}), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready_after", 128'(cw_ready), 128'(1));
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_writeback", regs_flat, 128'(0));
        chk("midrst_idle_busy", 128'(busy), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
